logic_gates_1: RTL and testbench

LOGIC_GATES_1 -- requirements
Module: logic_gates_1

---
 rtl/logic_gates_1_if.sv | 28 ++
 rtl/logic_gates_1.sv | 59 +++++
 tb/tb_logic_gates_1.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/logic_gates_1_if.sv
// Operand/select/result bundle for the selectable gate block.
// Latency: none; pure wiring between producer and the gate block.
// Backpressure: none; en is a sample qualifier, not a handshake.
interface logic_gates_1_if;
    logic       en;
    logic [2:0] sel;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       e;
    logic       f;
    logic       y;
    logic       y_comb;
    logic       valid;

    // Driver side: supplies operands and select, observes results.
    modport master (
        output en, sel, a, b, c, d, e, f,
        input  y, y_comb, valid
    );

    // Gate block side: consumes operands, produces results.
    modport slave (
        input  en, sel, a, b, c, d, e, f,
        output y, y_comb, valid
    );
endinterface

// File: rtl/logic_gates_1.sv
// Selectable six-input gate function with combinational and registered outputs.
// Latency: y_comb is combinational; y and valid appear one clk edge after en=1.
// Backpressure: none; en=0 simply holds y, valid reports the previous en.
module logic_gates_1 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    logic_gates_1_if.slave   bus
);

    logic       w_y_comb;
    logic [2:0] w_ones;
    logic       r_y;
    logic       r_valid;

    // Population count of the six operands, used by the majority-style code.
    assign w_ones = {2'b00, bus.a} + {2'b00, bus.b} + {2'b00, bus.c}
                  + {2'b00, bus.d} + {2'b00, bus.e} + {2'b00, bus.f};

    // Gate function selected by sel; every code is legal, X on operands propagates.
    always_comb begin
        w_y_comb = 1'b0;
        case (bus.sel)
            3'd0: w_y_comb = (bus.a & bus.b) | (bus.c & bus.d) | (bus.e & bus.f);
            3'd1: w_y_comb = (bus.a | bus.b) & (bus.c | bus.d) & (bus.e | bus.f);
            3'd2: w_y_comb = bus.a & bus.b & bus.c & bus.d & bus.e & bus.f;
            3'd3: w_y_comb = bus.a | bus.b | bus.c | bus.d | bus.e | bus.f;
            3'd4: w_y_comb = bus.a ^ bus.b ^ bus.c ^ bus.d ^ bus.e ^ bus.f;
            3'd5: w_y_comb = ~(bus.a & bus.b & bus.c & bus.d & bus.e & bus.f);
            3'd6: w_y_comb = ~(bus.a | bus.b | bus.c | bus.d | bus.e | bus.f);
            3'd7: w_y_comb = (w_ones >= 3'd4);
            default: w_y_comb = 1'b0;
        endcase
    end

    // Result register: loads on enabled edges, holds otherwise; reset is immediate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y <= RESET_VAL;
        end else if (bus.en) begin
            r_y <= w_y_comb;
        end
    end

    // valid tracks en one edge late, marking a freshly sampled y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.en;
        end
    end

    assign bus.y_comb = w_y_comb;
    assign bus.y      = r_y;
    assign bus.valid  = r_valid;

endmodule

// File: tb/tb_logic_gates_1.sv
// Bench for logic_gates_1: directed vectors, exhaustive sweep, random run with async resets.
// Latency: checks y/valid 1 ns after each rising edge, y_comb 1 ns after input change.
// Backpressure: none; bench drives en directly.
module tb_logic_gates_1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic exp_y;
    logic exp_v;

    logic_gates_1_if bif ();

    logic_gates_1 #(.RESET_VAL(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference: s holds abcdef with a in the leftmost (MSB) position.
    function automatic logic ref_fn(input logic [2:0] s_sel, input logic [5:0] s);
        int ones;
        int pairs_all;
        int pairs_any;
        ones = 0;
        pairs_all = 0;
        pairs_any = 0;
        for (int i = 0; i < 6; i++) ones += int'(s[i]);
        for (int p = 0; p < 3; p++) begin
            if (s[2*p] && s[2*p+1]) pairs_all++;
            if (s[2*p] || s[2*p+1]) pairs_any++;
        end
        case (s_sel)
            3'd0: return pairs_all > 0;
            3'd1: return pairs_any == 3;
            3'd2: return ones == 6;
            3'd3: return ones > 0;
            3'd4: return (ones % 2) == 1;
            3'd5: return ones != 6;
            3'd6: return ones == 0;
            default: return ones >= 4;
        endcase
    endfunction

    task automatic drive(input logic [2:0] s_sel, input logic [5:0] s, input logic e);
        bif.sel = s_sel;
        bif.en  = e;
        bif.a   = s[5];
        bif.b   = s[4];
        bif.c   = s[3];
        bif.d   = s[2];
        bif.e   = s[1];
        bif.f   = s[0];
    endtask

    // One enabled/held cycle: drive, check y_comb, clock, check y and valid.
    task automatic step(input string tag, input logic [2:0] s_sel, input logic [5:0] s,
                        input logic e);
        logic r;
        drive(s_sel, s, e);
        r = ref_fn(s_sel, s);
        #1;
        chk({tag, "_ycomb"}, bif.y_comb, r);
        @(posedge clk);
        #1;
        if (e) exp_y = r;
        exp_v = e;
        chk({tag, "_y"}, bif.y, exp_y);
        chk({tag, "_valid"}, bif.valid, exp_v);
    endtask

    logic [5:0] v022 [4];
    logic [2:0] sel24 [5];
    logic       res24 [5];
    logic [2:0] sel25 [4];
    logic       res25 [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        v022[0] = 6'b100100; v022[1] = 6'b001100; v022[2] = 6'b100100; v022[3] = 6'b100101;
        sel24[0] = 3'd4; res24[0] = 1'b1;
        sel24[1] = 3'd7; res24[1] = 1'b0;
        sel24[2] = 3'd3; res24[2] = 1'b1;
        sel24[3] = 3'd2; res24[3] = 1'b0;
        sel24[4] = 3'd6; res24[4] = 1'b0;
        sel25[0] = 3'd7; res25[0] = 1'b1;
        sel25[1] = 3'd1; res25[1] = 1'b0;
        sel25[2] = 3'd5; res25[2] = 1'b1;
        sel25[3] = 3'd0; res25[3] = 1'b1;

        // Reset state, asserted before any clock edge and held across edges with en=1.
        rst = 1'b1;
        drive(3'd3, 6'b111111, 1'b1);
        #2;
        chk("rst_y_pre_edge", bif.y, 1'b0);
        chk("rst_valid_pre_edge", bif.valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y_held", bif.y, 1'b0);
        chk("rst_valid_held", bif.valid, 1'b0);
        chk("rst_ycomb_live", bif.y_comb, 1'b1);
        rst = 1'b0;
        exp_y = 1'b0;
        exp_v = 1'b0;

        // Documented sel=0 sequence with en=1.
        for (int i = 0; i < 4; i++) step($sformatf("seq%0d", i), 3'd0, v022[i], 1'b1);
        chk("seq_ycomb_last", bif.y_comb, 1'b0);

        // Load 1, then hold with en=0 and all-zero operands.
        step("load1", 3'd0, 6'b001100, 1'b1);
        step("hold", 3'd0, 6'b000000, 1'b0);
        chk("hold_y_is_1", bif.y, 1'b1);

        // Mid-cycle async reset with en=1 and y=1.
        step("preload", 3'd0, 6'b001100, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_y", bif.y, 1'b0);
        chk("async_rst_valid", bif.valid, 1'b0);
        chk("async_rst_ycomb", bif.y_comb, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_y = 1'b0;
        exp_v = 1'b0;
        step("post_rst", 3'd0, 6'b001100, 1'b1);

        // Fixed-operand select checks.
        for (int i = 0; i < 5; i++) begin
            drive(sel24[i], 6'b101001, 1'b0);
            #1;
            chk($sformatf("v101001_sel%0d", sel24[i]), bif.y_comb, res24[i]);
        end
        for (int i = 0; i < 4; i++) begin
            drive(sel25[i], 6'b111100, 1'b0);
            #1;
            chk($sformatf("v111100_sel%0d", sel25[i]), bif.y_comb, res25[i]);
        end
        @(posedge clk);
        #1;
        exp_v = 1'b0;
        chk("idle_valid", bif.valid, 1'b0);

        // Exhaustive sweep of all selects and operand values.
        for (int s = 0; s < 8; s++) begin
            for (int v = 0; v < 64; v++) begin
                step($sformatf("sw_s%0d_v%0d", s, v), 3'(s), 6'(v), 1'b1);
            end
        end

        // Random run with random enable and occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] rs;
            logic [5:0] rv;
            logic       re;
            logic       r;
            rs = 3'($urandom_range(7));
            rv = 6'($urandom_range(63));
            re = 1'($urandom_range(1));
            drive(rs, rv, re);
            r = ref_fn(rs, rv);
            #1;
            chk($sformatf("rnd%0d_ycomb", i), bif.y_comb, r);
            if ($urandom_range(15) == 0) begin
                rst = 1'b1;
                #1;
                exp_y = 1'b0;
                exp_v = 1'b0;
                chk($sformatf("rnd%0d_rst_y", i), bif.y, exp_y);
                chk($sformatf("rnd%0d_rst_valid", i), bif.valid, exp_v);
                rst = 1'b0;
            end
            @(posedge clk);
            #1;
            if (re) exp_y = r;
            exp_v = re;
            chk($sformatf("rnd%0d_y", i), bif.y, exp_y);
            chk($sformatf("rnd%0d_valid", i), bif.valid, exp_v);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
